// File: rtl/case_conv_arbiter.sv
// Two-requester arbiter in front of a shared ASCII case converter; result lands in a
// single registered valid/ready slot one cycle after acceptance, zero-bubble when drained.
module case_conv_arbiter #(
  parameter int CNT_W      = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic [1:0]       req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic [1:0]       req1_mode,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] chg_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOWER  = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_id_q, out_id_d;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   chg_count_q, chg_count_d;

  logic               slot_free;
  logic               can_grant;
  logic               gnt0, gnt1, any_gnt;
  logic [7:0]         sel_data;
  logic [1:0]         sel_mode;
  logic [7:0]         conv_data;

  // Letters move by 0x20 between cases; everything else passes through untouched.
  function automatic logic [7:0] case_conv(input logic [7:0] d, input logic [1:0] m);
    logic       is_u;
    logic       is_l;
    logic [7:0] r;
    is_u = (d >= 8'h41) && (d <= 8'h5A);
    is_l = (d >= 8'h61) && (d <= 8'h7A);
    r    = d;
    case (m)
      MODE_LOWER:  if (is_u) r = d + 8'h20;
      MODE_UPPER:  if (is_l) r = d - 8'h20;
      MODE_TOGGLE: begin
        if (is_u)      r = d + 8'h20;
        else if (is_l) r = d - 8'h20;
      end
      default:     r = d;
    endcase
    return r;
  endfunction

  assign slot_free = !out_valid_q || out_ready;
  assign can_grant = (state_q == ST_RUN) && en && slot_free;

  // rr_q=1 means req1 holds priority on the next contested cycle.
  assign gnt0    = can_grant && req0_valid && (!req1_valid || FIXED_PRIO || !rr_q);
  assign gnt1    = can_grant && req1_valid && !gnt0;
  assign any_gnt = gnt0 || gnt1;

  assign sel_data  = gnt1 ? req1_data : req0_data;
  assign sel_mode  = gnt1 ? req1_mode : req0_mode;
  assign conv_data = case_conv(sel_data, sel_mode);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          if (out_valid_q && !out_ready) state_d = ST_DRAIN;
          else                           state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_d        = rr_q;
    chg_count_d = chg_count_q;
    if (any_gnt) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_data;
      out_id_d    = gnt1;
      rr_d        = gnt0;
      if (conv_data != sel_data) begin
        chg_count_d = chg_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_id_q    <= 1'b0;
      rr_q        <= 1'b0;
      chg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_q        <= rr_d;
      chg_count_q <= chg_count_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign busy       = (state_q != ST_IDLE);
  assign chg_count  = chg_count_q;

endmodule

// File: tb/tb_case_conv_arbiter.sv
// Directed bench: round-robin instance (u_rr) and fixed-priority instance (u_fp) share stimulus.
module tb_case_conv_arbiter;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          req0_valid, req1_valid;
  logic [7:0]    req0_data, req1_data;
  logic [1:0]    req0_mode, req1_mode;
  logic          out_ready;

  logic          rr_r0, rr_r1, rr_ov, rr_oid, rr_busy;
  logic [7:0]    rr_od;
  logic [CW-1:0] rr_cnt;
  logic          fp_r0, fp_r1, fp_ov, fp_oid, fp_busy;
  logic [7:0]    fp_od;
  logic [CW-1:0] fp_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  case_conv_arbiter #(.CNT_W(CW), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .reset_n(reset_n), .en(en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_mode(req0_mode), .req0_ready(rr_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_mode(req1_mode), .req1_ready(rr_r1),
    .out_valid(rr_ov), .out_data(rr_od), .out_id(rr_oid), .out_ready(out_ready),
    .busy(rr_busy), .chg_count(rr_cnt)
  );

  case_conv_arbiter #(.CNT_W(CW), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset_n(reset_n), .en(en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_mode(req0_mode), .req0_ready(fp_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_mode(req1_mode), .req1_ready(fp_r1),
    .out_valid(fp_ov), .out_data(fp_od), .out_id(fp_oid), .out_ready(out_ready),
    .busy(fp_busy), .chg_count(fp_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    en         = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h41; req0_mode = 2'b01;
    req1_valid = 1'b1; req1_data = 8'h61; req1_mode = 2'b10;
    out_ready  = 1'b1;
    #1;
    chk("rst_out_valid", rr_ov, 0);
    chk("rst_ready0", rr_r0, 0);
    chk("rst_ready1", rr_r1, 0);
    chk("rst_cnt", rr_cnt, 0);
    chk("rst_busy", rr_busy, 0);
    tick(); tick();
    chk("rst_held_out_valid", rr_ov, 0);
    chk("rst_held_ready0", rr_r0, 0);

    // Leave reset with nothing requesting; first edge moves IDLE->RUN.
    reset_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("idle_busy", rr_busy, 0);
    tick();
    chk("run_busy", rr_busy, 1);
    chk("run_out_valid", rr_ov, 0);

    // Single requester conversions.
    req0_valid = 1'b1; req0_data = 8'h41; req0_mode = 2'b01;
    #1;
    chk("s1_ready0", rr_r0, 1);
    chk("s1_ready1", rr_r1, 0);
    tick();
    chk("s1_valid", rr_ov, 1);
    chk("s1_data", rr_od, 8'h61);
    chk("s1_id", rr_oid, 0);
    chk("s1_cnt", rr_cnt, 1);
    req0_data = 8'h7A; req0_mode = 2'b10;
    tick();
    chk("s2_data", rr_od, 8'h5A);
    chk("s2_cnt", rr_cnt, 2);
    req0_data = 8'h31; req0_mode = 2'b11;
    tick();
    chk("s3_data", rr_od, 8'h31);
    chk("s3_cnt", rr_cnt, 2);
    req0_valid = 1'b0;
    tick();
    chk("s4_drained", rr_ov, 0);

    // Both valid: last grant was req0, so req1 wins first; pass mode leaves count alone.
    req0_valid = 1'b1; req0_data = 8'h41; req0_mode = 2'b00;
    req1_valid = 1'b1; req1_data = 8'h42; req1_mode = 2'b00;
    #1;
    chk("rr0_ready1", rr_r1, 1);
    chk("rr0_ready0", rr_r0, 0);
    chk("fp0_ready1", fp_r1, 0);
    tick();
    chk("rr0_valid", rr_ov, 1);
    chk("rr0_id", rr_oid, 1);
    chk("rr0_data", rr_od, 8'h42);
    chk("fp0_id", fp_oid, 0);
    chk("fp0_data", fp_od, 8'h41);
    chk("fp0_ready1b", fp_r1, 0);
    tick();
    chk("rr1_valid", rr_ov, 1);
    chk("rr1_id", rr_oid, 0);
    chk("fp1_id", fp_oid, 0);
    chk("fp1_ready1", fp_r1, 0);
    tick();
    chk("rr2_valid", rr_ov, 1);
    chk("rr2_id", rr_oid, 1);
    chk("fp2_id", fp_oid, 0);
    tick();
    chk("rr3_valid", rr_ov, 1);
    chk("rr3_id", rr_oid, 0);
    chk("fp3_valid", fp_ov, 1);
    chk("fp3_id", fp_oid, 0);
    chk("rr_pass_cnt", rr_cnt, 2);
    chk("fp_pass_cnt", fp_cnt, 2);

    // Backpressure: 0x62 held for three stalled cycles, then zero-bubble reload.
    req1_valid = 1'b0; req0_data = 8'h62; req0_mode = 2'b00;
    tick();
    chk("bp_load", rr_od, 8'h62);
    out_ready = 1'b0; req0_data = 8'h63; req0_mode = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready0", rr_r0, 0);
      tick();
      chk("bp_valid", rr_ov, 1);
      chk("bp_data", rr_od, 8'h62);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready0", rr_r0, 1);
    tick();
    chk("bp_rel_valid", rr_ov, 1);
    chk("bp_rel_data", rr_od, 8'h43);
    chk("bp_rel_cnt", rr_cnt, 3);

    // Drain: enable drops while the slot is held.
    out_ready = 1'b0; en = 1'b0;
    #1;
    chk("dr_ready0_a", rr_r0, 0);
    tick();
    chk("dr_busy_a", rr_busy, 1);
    chk("dr_data_a", rr_od, 8'h43);
    en = 1'b1;
    #1;
    chk("dr_ignore_en_ready0", rr_r0, 0);
    tick();
    chk("dr_busy_b", rr_busy, 1);
    chk("dr_valid_b", rr_ov, 1);
    en = 1'b0; out_ready = 1'b1;
    #1;
    chk("dr_ready0_c", rr_r0, 0);
    tick();
    chk("dr_idle_busy", rr_busy, 0);
    chk("dr_idle_valid", rr_ov, 0);
    chk("dr_idle_ready0", rr_r0, 0);
    chk("dr_cnt", rr_cnt, 3);

    // Counter wrap at 4 bits: 16 changing conversions from 3 pass through 0 and back to 3.
    en = 1'b1; req0_data = 8'h41; req0_mode = 2'b01;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 12) chk("wrap_zero", rr_cnt, 0);
    end
    chk("wrap_full", rr_cnt, 3);
    chk("wrap_full_fp", fp_cnt, 3);
    chk("wrap_data", rr_od, 8'h61);

    // Asynchronous reset mid-transfer clears the slot without a clock edge.
    chk("pre_arst_valid", rr_ov, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", rr_ov, 0);
    chk("arst_busy", rr_busy, 0);
    chk("arst_cnt", rr_cnt, 0);
    chk("arst_ready0", rr_r0, 0);
    tick();
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/case_conv_arbiter.md
Name: case_conv_arbiter

Overview:
- Shares one 8-bit ASCII case-conversion unit between two streaming requesters (req0, req1).
- Each request carries a character and a 2-bit conversion mode. The block arbitrates between requesters, converts the granted character, and presents it on a single registered valid/ready output tagged with the requester id.
- Sits between character producers and a downstream consumer. A small FSM gates operation on an enable input and drains cleanly when enable is removed.

Parameters:
- CNT_W, 16, width of the changed-character counter (wraps modulo 2^CNT_W).
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = req0 always wins when both request.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  run enable.
- req0_valid  input  1  requester 0 has a character.
- req0_data  input  8  requester 0 character.
- req0_mode  input  2  00 pass, 01 to-lower, 10 to-upper, 11 toggle-case.
- req0_ready  output  1  requester 0 character accepted this cycle.
- req1_valid, req1_data, req1_mode, req1_ready: same as requester 0, for requester 1.
- out_valid  output  1  output register holds a converted character.
- out_data  output  8  converted character.
- out_id  output  1  requester that produced out_data.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  FSM not in IDLE.
- chg_count  output  CNT_W  number of accepted characters whose value was altered by conversion.

Behaviour:
- Reset (async assert, sync-released use):
  - FSM=IDLE.
  - out_valid=0, out_data=0, out_id=0.
  - chg_count=0, busy=0.
  - Round-robin pointer=0, so req0 has priority first.
  - reqN_ready=0 (combinational, forced low in IDLE).
- Reset mid-operation: any held output is discarded; no handshake completes in the reset cycle.
- FSM states:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0 and out_valid=1 and not (out_ready=1).
  - RUN -> IDLE when en=0 and the output slot is empty or draining this cycle.
  - DRAIN -> IDLE when out_valid=1 and out_ready=1.
  - DRAIN ignores en until IDLE is reached.
  - busy = (state != IDLE).
- Slot free: slot_free = !out_valid || out_ready.
- Grant (combinational), only in RUN with en=1 and slot_free:
  - Only one requester valid: that requester is granted.
  - Both valid with FIXED_PRIO=1: req0 is granted.
  - Both valid with FIXED_PRIO=0: the requester not granted last time is granted. The pointer updates only on an actual grant.
  - reqN_ready = grantN. At most one ready per cycle.
  - reqN_ready is never asserted unless reqN_valid=1.
- Conversion, pure function of data d and mode m:
  - isU = d in 0x41..0x5A; isL = d in 0x61..0x7A.
  - Lower: d+0x20 if isU.
  - Upper: d-0x20 if isL.
  - Toggle: d+0x20 if isU, d-0x20 if isL.
  - Pass: d unchanged.
  - Non-letters are always unchanged. The result is 8 bits, with no carry or borrow possible.
- Latency: a character accepted in cycle N appears with out_valid=1 in cycle N+1 (one register stage).
- Output register:
  - On a grant: out_valid<=1 and out_data/out_id load.
  - Else if out_ready: out_valid<=0.
  - Simultaneous drain and grant: new data loads and out_valid stays 1, giving zero-bubble throughput of 1 char/cycle.
  - out_data/out_id stay stable while out_valid=1 and out_ready=0.
  - out_ready is ignored while out_valid=0.
- chg_count increments by 1 in each grant cycle where the converted value != input value. It wraps from all-ones to 0.
- en deasserted: no new grants that cycle. A held output is still delivered.

Test Plan:
- Reset: reset_n=0 with both requesters valid -> out_valid=0, reqN_ready=0, chg_count=0, busy=0. Async assert mid-transfer clears out_valid immediately.
- Single requester, req0 0x41 mode 01, en=1, out_ready=1 -> next cycle out_data=0x61, out_id=0, chg_count=1. req0 0x7A mode 10 -> 0x5A. req0 0x31 mode 11 -> 0x31 with chg_count unchanged.
- Both requesters valid continuously, FIXED_PRIO=0, out_ready=1 -> out_id alternates 0,1,0,1 with out_valid=1 every cycle. FIXED_PRIO=1 -> out_id all 0 and req1_ready never asserts.
- Backpressure: out_ready=0 for 3 cycles with data 0x62 held -> out_data stable at 0x62 and reqN_ready=0 throughout. out_ready=1 with a pending request -> new data loads the same cycle, no bubble.
- Drain: en drops while out_valid=1 and out_ready=0 -> state DRAIN, busy=1, no grants. out_ready=1 -> IDLE and busy=0 next cycle.
- Counter wrap with CNT_W=4: 16 changing conversions -> chg_count returns to 0. Mode 00 on 0x41 -> chg_count unchanged.
